uart_rx_fifo_ctrl: RTL and testbench
====================================

# uart_rx_fifo_ctrl

Receive-side FIFO controller for the UART. It takes completed bytes from the UART Rx controller, which runs in the UART clock domain, and synchronizes the byte-done strobe into DSP_CLK. Bytes are buffered in a 16-entry FIFO (or a 1-entry holding register when the FIFO is disabled) and presented to the DSP bus as a pop-on-read data register plus a status register. It also generates trigger-level, overrun and receive-timeout indications for the interrupt logic.

## Interface
- TIMEOUT_CYCLES, 4096: DSP_CLK cycles of inactivity with a non-empty FIFO before RxTimeout asserts; range 2..65535.
- RESETn  in  1  asynchronous, active-low reset.
- DSP_CLK  in  1  DSP bus clock; all state is in this domain.
- DSP_CEn  in  1  chip enable, active low.
- DSP_OEn  in  1  read strobe, active low; may be held for several cycles.
- DSP_ADDR  in  4  0x0 = Rx data (pop), 0x1 = Rx status (clears overrun).
- DSP_RDATA  out  32  read data; combinational from current state.
- FIFOEn  in  1  1 = 16-deep FIFO, 0 = 1-deep holding register.
- RxDone  in  1  level from Rx controller, UART domain; rises when RxData is valid. RxData is held stable until the next RxDone rise.
- RxData  in  8  received byte, UART domain.
- RxFIFO_Empty, RxFIFO_Full  out  1  FIFO level == 0, and level == depth (16, or 1 when FIFOEn=0).
- RxFIFO_L14/L8/L4/L1_Full  out  1  level >= 14/8/4/1.
- RxOverrun  out  1  sticky; a byte was dropped because the FIFO was full.
- RxTimeout  out  1  timeout condition reached.

## Operation
- RxDone passes through a 3-flop chain s0→s1→s2. A push event fires on s1 & !s2. RxData is sampled into the FIFO on that same edge.
- Read strobe: rd = !DSP_CEn & !DSP_OEn. It is registered as rd_q. A pop fires on rd & !rd_q & ADDR==0x0 & !Empty, so exactly one pop occurs per strobe regardless of how long it is held.
- DSP_RDATA:
  - ADDR 0x0 with rd asserted: {24'h0, FIFO[rp]}, or 32'h0 when empty.
  - ADDR 0x1 with rd asserted: {25'h0, Timeout, Overrun, L8, L4, L1, Full, Empty}.
  - Otherwise 32'h0.
- Overrun is cleared on the first cycle of a read strobe to 0x1. If set and clear land on the same edge, set wins.
- Pointers wp and rp are 5 bits; level = wp − rp (mod 32), range 0..16. Storage is indexed by ptr[3:0].
- Push when not full: write the byte and increment wp. Push when full: drop the byte, leave wp unchanged, set Overrun.
- Simultaneous push and pop: both take effect and the level is unchanged. On a full FIFO a simultaneous push is accepted, because the pop frees a slot that edge.
- FIFOEn=0: depth is 1. Only entry 0 is used; level stays in 0..1.
- Any FIFOEn transition (detected against a registered copy) flushes the FIFO: wp = rp = 0, Overrun = 0, timeout counter = 0. A push on the flush edge is discarded.
- Timeout counter is 16 bits:
  - It clears on push, pop, flush, or Empty.
  - Otherwise it increments, saturating at TIMEOUT_CYCLES−1.
  - RxTimeout = (count == TIMEOUT_CYCLES−1) & !Empty.

## Timing
- Reset values: every output is 0 except RxFIFO_Empty = 1. wp, rp, counter, sync chain and rd_q are 0; storage is 8'h00.
- RxDone rise captured at edge N (s0): push occurs at edge N+2. Empty falls and the level increments after N+2.
- Pop: the data is valid on DSP_RDATA during the first strobe cycle. The pointer advances at the end of that cycle, so later cycles of the same strobe show the next entry.
- RxTimeout asserts exactly TIMEOUT_CYCLES−1 edges after the last push/pop with the FIFO non-empty. It deasserts on the edge of the next push, pop, or flush.
- RESETn is asynchronous and may assert mid-strobe or mid-sync. All state is cleared immediately. An RxDone that is already high at reset release is treated as a new push once it reaches s1.

## Structure
- Shared package `uart_pkg`: address constants RX_DATA_ADDR = 4'h0 and RX_STAT_ADDR = 4'h1, FIFO depth 16, and the pointer width 5. The Tx FIFO controller uses the same constants.
- One sub-module, `uart_sync_edge`: a 3-flop synchronizer with a rising-edge pulse output. It is instantiated for RxDone and is reusable on the Tx side.

## Test plan
- Push 0x11, 0x22, 0x33 via RxDone, then three single-cycle reads of 0x0 → RDATA 0x11, 0x22, 0x33 in order; Empty=1 afterwards; a fourth read returns 0x00.
- 17 pushes with FIFOEn=1 → Full=1 after the 16th; the 17th byte is dropped and Overrun=1. Status read returns bit1=1 and Overrun clears next cycle. The data read still returns byte 1.
- Read strobe held 5 cycles on 0x0 with 3 bytes stored → exactly one pop; level goes 3→2.
- Simultaneous push and pop at level 16 → level stays 16, no Overrun, and the new byte is last out.
- FIFOEn=0: push 0xA5, then push 0x5A without reading → Full=1, Overrun=1, read returns 0xA5. Toggling FIFOEn then flushes: Empty=1, Overrun=0.
- TIMEOUT_CYCLES=8: one push, then idle → RxTimeout=1 exactly 7 edges after the push edge; it clears on the pop edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and types, used by both the Rx and Tx FIFO controllers.
package uart_pkg;

  localparam int PTR_W      = 5;
  localparam int FIFO_DEPTH = 16;

  typedef logic [3:0]       addr_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam addr_t RX_DATA_ADDR = 4'h0;
  localparam addr_t RX_STAT_ADDR = 4'h1;

  // Rx status register layout, MSB first.
  typedef struct packed {
    logic timeout;
    logic overrun;
    logic l8;
    logic l4;
    logic l1;
    logic full;
    logic empty;
  } rx_stat_t;

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// DSP bus read port: the CPU side drives strobes and address, the block returns data.
interface uart_rx_fifo_ctrl_if;
  import uart_pkg::*;

  logic        DSP_CEn;
  logic        DSP_OEn;
  addr_t       DSP_ADDR;
  logic [31:0] DSP_RDATA;

  modport master (output DSP_CEn, output DSP_OEn, output DSP_ADDR, input DSP_RDATA);
  modport slave  (input DSP_CEn, input DSP_OEn, input DSP_ADDR, output DSP_RDATA);

endinterface

// File: rtl/uart_sync_edge.sv
// Three-flop synchronizer for a slow level from another clock domain,
// producing a one-cycle pulse on each rising edge of the synchronized level.
module uart_sync_edge (
  input  logic RESETn,
  input  logic DSP_CLK,
  input  logic din,
  output logic rise
);

  logic s0, s1, s2;

  // s0/s1 resolve metastability; s2 holds the previous settled value for edge detection.
  // NOTE: registers take non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= din;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller: synchronizes byte-done from the UART domain,
// buffers bytes (16-deep or a single holding register), and exposes a
// pop-on-read data register, a status register and interrupt-level flags.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                RESETn,
  input  logic                DSP_CLK,
  uart_rx_fifo_ctrl_if.slave  dsp,
  input  logic                FIFOEn,
  input  logic                RxDone,
  input  logic [7:0]          RxData,
  output logic                RxFIFO_Empty,
  output logic                RxFIFO_Full,
  output logic                RxFIFO_L14_Full,
  output logic                RxFIFO_L8_Full,
  output logic                RxFIFO_L4_Full,
  output logic                RxFIFO_L1_Full,
  output logic                RxOverrun,
  output logic                RxTimeout
);

  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES - 1);

  logic        push_ev, push_ok, push_drop;
  logic        rd, rd_q, rd_start, pop, stat_clr;
  logic        fifo_en_q, flush;
  logic        empty, full, overrun;
  ptr_t        wp, rp, level, depth;
  logic [3:0]  wr_idx, rd_idx;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [15:0] to_cnt;
  rx_stat_t    stat;

  uart_sync_edge u_rx_done_sync (
    .RESETn  (RESETn),
    .DSP_CLK (DSP_CLK),
    .din     (RxDone),
    .rise    (push_ev)
  );

  assign level  = wp - rp;
  assign depth  = FIFOEn ? ptr_t'(FIFO_DEPTH) : ptr_t'(1);
  assign empty  = (level == '0);
  assign full   = (level == depth);
  // The holding-register mode only ever uses entry 0.
  assign wr_idx = FIFOEn ? wp[3:0] : 4'h0;
  assign rd_idx = FIFOEn ? rp[3:0] : 4'h0;

  // A strobe acts once on its first cycle, however long it is held.
  assign rd       = ~dsp.DSP_CEn & ~dsp.DSP_OEn;
  assign rd_start = rd & ~rd_q;
  assign pop      = rd_start & (dsp.DSP_ADDR == RX_DATA_ADDR) & ~empty;
  assign stat_clr = rd_start & (dsp.DSP_ADDR == RX_STAT_ADDR);
  assign flush    = FIFOEn ^ fifo_en_q;

  // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
  assign push_ok   = push_ev & ~flush & (~full | pop);
  assign push_drop = push_ev & ~flush & full & ~pop;

  // Remember last strobe level and FIFO mode for edge/transition detection.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_q      <= 1'b0;
      fifo_en_q <= 1'b0;
    end else begin
      rd_q      <= rd;
      fifo_en_q <= FIFOEn;
    end
  end

  // Advance write/read pointers; a mode change empties the FIFO.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + ptr_t'(1);
      if (pop)     rp <= rp + ptr_t'(1);
    end
  end

  // Byte storage, cleared on reset so reads of stale slots are deterministic.
  // NOTE: this array is reset explicitly, so it maps to flops rather than a RAM macro.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else if (push_ok) begin
      mem[wr_idx] <= RxData;
    end
  end

  // Sticky overrun: set on a dropped byte (set beats clear), cleared by a status read.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      overrun <= 1'b0;
    end else if (flush) begin
      overrun <= 1'b0;
    end else if (push_drop) begin
      overrun <= 1'b1;
    end else if (stat_clr) begin
      overrun <= 1'b0;
    end
  end

  // Inactivity counter: restarts on any traffic or when empty, saturates at the limit.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      to_cnt <= '0;
    end else if (flush || push_ev || pop || empty) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign RxTimeout       = (to_cnt == TO_MAX) & ~empty;
  assign RxOverrun       = overrun;
  assign RxFIFO_Empty    = empty;
  assign RxFIFO_Full     = full;
  assign RxFIFO_L14_Full = (level >= ptr_t'(14));
  assign RxFIFO_L8_Full  = (level >= ptr_t'(8));
  assign RxFIFO_L4_Full  = (level >= ptr_t'(4));
  assign RxFIFO_L1_Full  = (level >= ptr_t'(1));

  assign stat = {RxTimeout, overrun, RxFIFO_L8_Full, RxFIFO_L4_Full,
                 RxFIFO_L1_Full, full, empty};

  // Read-data mux, driven only while a read strobe is active.
  // NOTE: the default assignment up front keeps this purely combinational (no latch).
  always_comb begin
    dsp.DSP_RDATA = '0;
    if (rd) begin
      case (dsp.DSP_ADDR)
        RX_DATA_ADDR: if (!empty) dsp.DSP_RDATA = {24'h0, mem[rd_idx]};
        RX_STAT_ADDR: dsp.DSP_RDATA = {25'h0, stat};
        default:      dsp.DSP_RDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed stimulus with a scoreboard queue of
// expected read data, drained by an independent bus monitor.
module tb_uart_rx_fifo_ctrl;

  logic       RESETn;
  logic       DSP_CLK;
  logic       FIFOEn;
  logic       RxDone;
  logic [7:0] RxData;
  logic       RxFIFO_Empty, RxFIFO_Full, RxFIFO_L14_Full, RxFIFO_L8_Full;
  logic       RxFIFO_L4_Full, RxFIFO_L1_Full, RxOverrun, RxTimeout;

  uart_rx_fifo_ctrl_if bus ();

  uart_rx_fifo_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .RESETn          (RESETn),
    .DSP_CLK         (DSP_CLK),
    .dsp             (bus),
    .FIFOEn          (FIFOEn),
    .RxDone          (RxDone),
    .RxData          (RxData),
    .RxFIFO_Empty    (RxFIFO_Empty),
    .RxFIFO_Full     (RxFIFO_Full),
    .RxFIFO_L14_Full (RxFIFO_L14_Full),
    .RxFIFO_L8_Full  (RxFIFO_L8_Full),
    .RxFIFO_L4_Full  (RxFIFO_L4_Full),
    .RxFIFO_L1_Full  (RxFIFO_L1_Full),
    .RxOverrun       (RxOverrun),
    .RxTimeout       (RxTimeout)
  );

  initial DSP_CLK = 1'b0;
  always #5 DSP_CLK = ~DSP_CLK;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // {Empty, Full, L14, L8, L4, L1, Overrun, Timeout}
  function automatic logic [7:0] pins();
    return {RxFIFO_Empty, RxFIFO_Full, RxFIFO_L14_Full, RxFIFO_L8_Full,
            RxFIFO_L4_Full, RxFIFO_L1_Full, RxOverrun, RxTimeout};
  endfunction

  task automatic tick();
    @(posedge DSP_CLK);
    #1;
  endtask

  task automatic expect_read(input string nm, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Raise RxDone (push lands on the 3rd edge), then drop it and let the synchronizer settle.
  task automatic push_byte(input logic [7:0] b);
    RxData = b;
    RxDone = 1'b1;
    repeat (3) tick();
    RxDone = 1'b0;
    repeat (3) tick();
  endtask

  // Single-cycle read strobe.
  task automatic bus_read(input logic [3:0] a, input string nm, input logic [31:0] v);
    expect_read(nm, v);
    bus.DSP_ADDR = a;
    bus.DSP_CEn  = 1'b0;
    bus.DSP_OEn  = 1'b0;
    tick();
    bus.DSP_CEn  = 1'b1;
    bus.DSP_OEn  = 1'b1;
    tick();
  endtask

  // Monitor: compares read data on the first cycle of every strobe, away from the clock edge.
  logic mon_rd_prev = 1'b0;
  logic mon_rd_now;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge DSP_CLK);
      mon_rd_now = !bus.DSP_CEn && !bus.DSP_OEn;
      if (mon_rd_now && !mon_rd_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_read", bus.DSP_RDATA, 32'hxxxx_xxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check(mon_e.name, bus.DSP_RDATA, mon_e.val);
        end
      end
      mon_rd_prev = mon_rd_now;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESETn       = 1'b0;
    FIFOEn       = 1'b1;
    RxDone       = 1'b0;
    RxData       = 8'h00;
    bus.DSP_CEn  = 1'b1;
    bus.DSP_OEn  = 1'b1;
    bus.DSP_ADDR = 4'h0;

    // Reset state
    repeat (3) tick();
    check("reset_pins", 32'(pins()), 32'h80);
    check("reset_rdata", bus.DSP_RDATA, 32'h0);
    RESETn = 1'b1;
    repeat (3) tick();
    check("post_reset_pins", 32'(pins()), 32'h80);

    // Basic ordering, empty read, unmapped address
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("t1_level3_pins", 32'(pins()), 32'h04);
    bus_read(4'h0, "t1_rd0", 32'h11);
    bus_read(4'h0, "t1_rd1", 32'h22);
    bus_read(4'h0, "t1_rd2", 32'h33);
    check("t1_empty_pins", 32'(pins()), 32'h80);
    bus_read(4'h0, "t1_rd_empty", 32'h00);
    bus_read(4'h1, "t1_stat_empty", 32'h01);
    bus_read(4'h2, "t1_unmapped", 32'h00);

    // Held strobe pops exactly once
    push_byte(8'h71);
    push_byte(8'h72);
    push_byte(8'h73);
    expect_read("t3_held_first", 32'h71);
    bus.DSP_ADDR = 4'h0;
    bus.DSP_CEn  = 1'b0;
    bus.DSP_OEn  = 1'b0;
    repeat (3) tick();
    check("t3_held_next", bus.DSP_RDATA, 32'h72);
    repeat (2) tick();
    bus.DSP_CEn = 1'b1;
    bus.DSP_OEn = 1'b1;
    tick();
    bus_read(4'h0, "t3_rd_after_hold", 32'h72);
    bus_read(4'h0, "t3_rd_last", 32'h73);
    bus_read(4'h1, "t3_stat_empty", 32'h01);

    // Fill to 16, overflow by one, status read clears overrun
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    check("t2_full_pins", 32'(pins()), 32'h7C);
    push_byte(8'h50);
    check("t2_overrun_set", 32'(RxOverrun), 32'h1);
    check("t2_still_full", 32'(RxFIFO_Full), 32'h1);
    bus_read(4'h1, "t2_stat_ovr", 32'h3E);
    check("t2_overrun_cleared", 32'(RxOverrun), 32'h0);
    bus_read(4'h1, "t2_stat_no_ovr", 32'h1E);
    bus_read(4'h0, "t2_rd_first", 32'h40);

    // Refill to 16, then push and pop on the same edge
    push_byte(8'h60);
    check("t4_full_again", 32'(pins()), 32'h7C);
    RxData = 8'h61;
    RxDone = 1'b1;
    repeat (2) tick();
    expect_read("t4_pop_at_full", 32'h41);
    bus.DSP_ADDR = 4'h0;
    bus.DSP_CEn  = 1'b0;
    bus.DSP_OEn  = 1'b0;
    tick();
    bus.DSP_CEn = 1'b1;
    bus.DSP_OEn = 1'b1;
    RxDone      = 1'b0;
    check("t4_level16_no_ovr", 32'(pins()), 32'h7C);
    repeat (3) tick();
    for (int i = 2; i < 16; i++) bus_read(4'h0, "t4_drain", 32'h40 + 32'(i));
    bus_read(4'h0, "t4_drain_60", 32'h60);
    bus_read(4'h0, "t4_new_last", 32'h61);
    check("t4_empty_pins", 32'(pins()), 32'h80);

    // Single holding register, then flush by mode change
    FIFOEn = 1'b0;
    repeat (2) tick();
    push_byte(8'hA5);
    push_byte(8'h5A);
    check("t5_hold_full_ovr", 32'(pins()), 32'h46);
    bus_read(4'h0, "t5_rd_a5", 32'hA5);
    push_byte(8'h3C);
    check("t5_hold_refill", 32'(pins()), 32'h46);
    FIFOEn = 1'b1;
    repeat (2) tick();
    check("t5_flushed_pins", 32'(pins()), 32'h80);
    bus_read(4'h0, "t5_rd_flushed", 32'h00);

    // Receive timeout: asserts 7 edges after the push, clears on the pop edge
    RxData = 8'h99;
    RxDone = 1'b1;
    repeat (3) tick();
    RxDone = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t6_timeout_edge%0d", k), 32'(RxTimeout), (k >= 7) ? 32'h1 : 32'h0);
      tick();
    end
    expect_read("t6_rd_99", 32'h99);
    bus.DSP_ADDR = 4'h0;
    bus.DSP_CEn  = 1'b0;
    bus.DSP_OEn  = 1'b0;
    tick();
    check("t6_timeout_cleared", 32'(RxTimeout), 32'h0);
    bus.DSP_CEn = 1'b1;
    bus.DSP_OEn = 1'b1;
    tick();
    check("t6_end_pins", 32'(pins()), 32'h80);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
